// File: rtl/cpu7_tlb_dmw.sv
// cpu7_tlb_dmw: translates virtual to physical addresses through a set of
// direct-mapped windows, or passes them through in direct-address mode. The
// result travels down a fixed-latency pipeline to the cache side.
//
// Handshake: tlb_req is a valid-only strobe with no ready. Every request is
// accepted unless tlb_cancel is high in the same cycle. tlb_finish is a
// one-cycle valid pulse exactly LATENCY cycles after its request, with no
// ready. While tlb_finish is low, the result outputs hold the last finished
// value.
module cpu7_tlb_dmw #(
    parameter int VA_W    = 32,
    parameter int PA_W    = 32,
    parameter int NUM_WIN = 2,
    parameter int LATENCY = 1,
    parameter int SEG_W   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tlb_req,
    input  logic [VA_W-1:0]    tlb_vaddr,
    input  logic               tlb_cancel,
    input  logic               da_mode,
    input  logic               da_uncache,
    input  logic               cfg_wen,
    input  logic [1:0]         cfg_idx,
    input  logic [2*SEG_W+1:0] cfg_wdata,
    output logic               tlb_finish,
    output logic               tlb_hit,
    output logic [PA_W-1:0]    tlb_paddr,
    output logic               tlb_uncache,
    output logic [5:0]         tlb_exccode,
    output logic               tlb_busy
);
    // Each result is packed as {hit, paddr, uncache, exccode}.
    localparam int         RES_W    = PA_W + 8;
    localparam logic [5:0] EXC_TLBR = 6'h3F;

    // Reject unsupported window counts and latencies at elaboration.
    generate
        if (LATENCY < 1 || LATENCY > 4 || NUM_WIN < 1 || NUM_WIN > 4) begin : g_bad_param
            $error("cpu7_tlb_dmw: LATENCY and NUM_WIN must each be in 1..4");
        end
    endgenerate

    logic [NUM_WIN-1:0] win_valid;
    logic [NUM_WIN-1:0] win_mat;
    logic [SEG_W-1:0]   win_pseg [NUM_WIN];
    logic [SEG_W-1:0]   win_vseg [NUM_WIN];

    logic               hit_c;
    logic [PA_W-1:0]    paddr_c;
    logic               unc_c;
    logic [5:0]         exc_c;
    logic [RES_W-1:0]   res_c;

    logic [LATENCY-1:0] st_valid;
    logic [RES_W-1:0]   st_res [LATENCY];

    // Window registers. A write to an index beyond NUM_WIN matches no window and is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_valid <= '0;
            win_mat   <= '0;
            for (int w = 0; w < NUM_WIN; w++) begin
                win_pseg[w] <= '0;
                win_vseg[w] <= '0;
            end
        end else if (cfg_wen) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                if (int'(cfg_idx) == w) begin
                    win_valid[w] <= cfg_wdata[2*SEG_W+1];
                    win_mat[w]   <= cfg_wdata[2*SEG_W];
                    win_pseg[w]  <= cfg_wdata[2*SEG_W-1:SEG_W];
                    win_vseg[w]  <= cfg_wdata[SEG_W-1:0];
                end
            end
        end
    end

    // Lookup on the current window registers. The loop scans downwards so the lowest matching index wins.
    always_comb begin
        hit_c   = 1'b0;
        paddr_c = tlb_vaddr[PA_W-1:0];
        unc_c   = 1'b0;
        exc_c   = EXC_TLBR;
        if (da_mode) begin
            hit_c = 1'b1;
            unc_c = da_uncache;
            exc_c = 6'h00;
        end else begin
            for (int w = NUM_WIN - 1; w >= 0; w--) begin
                if (win_valid[w] && (tlb_vaddr[VA_W-1 -: SEG_W] == win_vseg[w])) begin
                    hit_c   = 1'b1;
                    paddr_c = {win_pseg[w], tlb_vaddr[PA_W-SEG_W-1:0]};
                    unc_c   = ~win_mat[w];
                    exc_c   = 6'h00;
                end
            end
        end
    end

    assign res_c = {hit_c, paddr_c, unc_c, exc_c};

    // Result pipeline. Data loads only behind a valid bit, so the last stage holds the last finished result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_valid <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                st_res[s] <= '0;
            end
        end else begin
            st_valid[0] <= tlb_req && !tlb_cancel;
            if (tlb_req && !tlb_cancel) begin
                st_res[0] <= res_c;
            end
            for (int s = 1; s < LATENCY; s++) begin
                st_valid[s] <= st_valid[s-1] && !tlb_cancel;
                if (st_valid[s-1] && !tlb_cancel) begin
                    st_res[s] <= st_res[s-1];
                end
            end
        end
    end

    assign tlb_finish = st_valid[LATENCY-1];
    assign {tlb_hit, tlb_paddr, tlb_uncache, tlb_exccode} = st_res[LATENCY-1];
    assign tlb_busy = |st_valid;

endmodule

// File: tb/tb_cpu7_tlb_dmw.sv
// tb_cpu7_tlb_dmw: drives one LATENCY=1 and one LATENCY=3 instance from
// shared inputs. A reference model predicts each result, and the scoreboard
// checks finishes, busy and held outputs every cycle.
module tb_cpu7_tlb_dmw;
    localparam int EW = 40;  // {hit, paddr[31:0], uncache, exccode[5:0]}
    localparam int NW = 2;

    logic        clk;
    logic        resetn;
    logic        tlb_req;
    logic [31:0] tlb_vaddr;
    logic        tlb_cancel;
    logic        da_mode;
    logic        da_uncache;
    logic        cfg_wen;
    logic [1:0]  cfg_idx;
    logic [7:0]  cfg_wdata;

    logic        f1, h1, u1, b1;
    logic [31:0] p1;
    logic [5:0]  e1;
    logic        f3, h3, u3, b3;
    logic [31:0] p3;
    logic [5:0]  e3;

    cpu7_tlb_dmw #(.VA_W(32), .PA_W(32), .NUM_WIN(NW), .LATENCY(1), .SEG_W(3)) dut1 (
        .clk(clk), .resetn(resetn), .tlb_req(tlb_req), .tlb_vaddr(tlb_vaddr),
        .tlb_cancel(tlb_cancel), .da_mode(da_mode), .da_uncache(da_uncache),
        .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
        .tlb_finish(f1), .tlb_hit(h1), .tlb_paddr(p1), .tlb_uncache(u1),
        .tlb_exccode(e1), .tlb_busy(b1)
    );

    cpu7_tlb_dmw #(.VA_W(32), .PA_W(32), .NUM_WIN(NW), .LATENCY(3), .SEG_W(3)) dut3 (
        .clk(clk), .resetn(resetn), .tlb_req(tlb_req), .tlb_vaddr(tlb_vaddr),
        .tlb_cancel(tlb_cancel), .da_mode(da_mode), .da_uncache(da_uncache),
        .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
        .tlb_finish(f3), .tlb_hit(h3), .tlb_paddr(p3), .tlb_uncache(u3),
        .tlb_exccode(e3), .tlb_busy(b3)
    );

    logic          fin  [2];
    logic          busy [2];
    logic [EW-1:0] res  [2];
    assign fin[0]  = f1;
    assign fin[1]  = f3;
    assign busy[0] = b1;
    assign busy[1] = b3;
    assign res[0]  = {h1, p1, u1, e1};
    assign res[1]  = {h3, p3, u3, e3};

    // Scoreboard state: expected results, their due cycles, and the held values.
    logic [EW-1:0] exp_q [2][$];
    int            due_q [2][$];
    logic [EW-1:0] held  [2];

    // Reference window configuration.
    logic       m_v    [4];
    logic       m_mat  [4];
    logic [2:0] m_pseg [4];
    logic [2:0] m_vseg [4];

    int cyc;
    int n_cmp;
    int n_bad;

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [EW-1:0] model(input logic [31:0] va, input logic da, input logic dau);
        if (da) return {1'b1, va, dau, 6'h00};
        for (int w = 0; w < NW; w++) begin
            if (m_v[w] && va[31:29] == m_vseg[w]) return {1'b1, m_pseg[w], va[28:0], ~m_mat[w], 6'h00};
        end
        return {1'b0, va, 1'b0, 6'h3F};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            due_q[k].delete();
            held[k] = '0;
        end
        for (int w = 0; w < 4; w++) begin
            m_v[w] = 1'b0; m_mat[w] = 1'b0; m_pseg[w] = '0; m_vseg[w] = '0;
        end
    endtask

    // One clock: sample inputs at the rising edge, check outputs at the falling edge.
    task automatic step();
        logic [EW-1:0] e;
        logic          exp_b;
        @(posedge clk);
        if (resetn === 1'b1) begin
            if (tlb_cancel) begin
                for (int k = 0; k < 2; k++) begin
                    exp_q[k].delete();
                    due_q[k].delete();
                end
            end else if (tlb_req) begin
                e = model(tlb_vaddr, da_mode, da_uncache);
                for (int k = 0; k < 2; k++) begin
                    exp_q[k].push_back(e);
                    due_q[k].push_back(cyc + lat_of(k));
                end
            end
            if (cfg_wen && cfg_idx < NW) begin
                m_v[cfg_idx]    = cfg_wdata[7];
                m_mat[cfg_idx]  = cfg_wdata[6];
                m_pseg[cfg_idx] = cfg_wdata[5:3];
                m_vseg[cfg_idx] = cfg_wdata[2:0];
            end
        end
        cyc++;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_b = (exp_q[k].size() != 0);
            n_cmp++;
            if (busy[k] !== exp_b) begin
                n_bad++;
                $display("FAIL busy_L%0d cyc=%0d got=%b exp=%b", lat_of(k), cyc, busy[k], exp_b);
            end
            if (fin[k] === 1'b1) begin
                n_cmp++;
                if (exp_q[k].size() == 0 || due_q[k][0] != cyc) begin
                    n_bad++;
                    $display("FAIL finish_unexpected_L%0d cyc=%0d got=1 exp=0", lat_of(k), cyc);
                end else begin
                    e = exp_q[k].pop_front();
                    void'(due_q[k].pop_front());
                    if (res[k] !== e) begin
                        n_bad++;
                        $display("FAIL result_L%0d cyc=%0d got=%h exp=%h", lat_of(k), cyc, res[k], e);
                    end
                    held[k] = e;
                end
            end else begin
                if (exp_q[k].size() != 0 && due_q[k][0] == cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL finish_missing_L%0d cyc=%0d got=%b exp=1", lat_of(k), cyc, fin[k]);
                    void'(exp_q[k].pop_front());
                    void'(due_q[k].pop_front());
                end
                n_cmp++;
                if (res[k] !== held[k]) begin
                    n_bad++;
                    $display("FAIL hold_L%0d cyc=%0d got=%h exp=%h", lat_of(k), cyc, res[k], held[k]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        tlb_req = 1'b0; tlb_cancel = 1'b0; cfg_wen = 1'b0;
        repeat (n) step();
    endtask

    task automatic write_win(input logic [1:0] idx, input logic [7:0] data);
        cfg_wen = 1'b1; cfg_idx = idx; cfg_wdata = data;
        step();
        cfg_wen = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        tlb_req = 1'b0; tlb_vaddr = '0; tlb_cancel = 1'b0; da_mode = 1'b0;
        da_uncache = 1'b0; cfg_wen = 1'b0; cfg_idx = '0; cfg_wdata = '0;
        clear_model();
        #1 resetn = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({f1, h1, p1, u1, e1, b1} !== '0) begin
            n_bad++; $display("FAIL reset_L1 got=%h exp=0", {f1, h1, p1, u1, e1, b1});
        end
        n_cmp++;
        if ({f3, h3, p3, u3, e3, b3} !== '0) begin
            n_bad++; $display("FAIL reset_L3 got=%h exp=0", {f3, h3, p3, u3, e3, b3});
        end
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_da();
        da_mode = 1'b1; da_uncache = 1'b0; tlb_req = 1'b1; tlb_vaddr = 32'h1C000040;
        step();
        tlb_req = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b1, 32'h1C000040, 1'b0, 6'h00}) begin
            n_bad++; $display("FAIL da_finish got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b1, 32'h1C000040, 1'b0, 6'h00});
        end
        step();
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b0, 1'b1, 32'h1C000040, 1'b0, 6'h00}) begin
            n_bad++; $display("FAIL da_hold got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b0, 1'b1, 32'h1C000040, 1'b0, 6'h00});
        end
        da_mode = 1'b0;
        idle(4);
    endtask

    task automatic test_window();
        write_win(2'd0, 8'hC5);  // valid, cached, pseg 0, vseg 5
        tlb_req = 1'b1; tlb_vaddr = 32'hA0001234;
        step();
        tlb_req = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b1, 32'h00001234, 1'b0, 6'h00}) begin
            n_bad++; $display("FAIL window_cached got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b1, 32'h00001234, 1'b0, 6'h00});
        end
        write_win(2'd0, 8'h85);  // same window, uncached
        tlb_req = 1'b1;
        step();
        tlb_req = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b1, 32'h00001234, 1'b1, 6'h00}) begin
            n_bad++; $display("FAIL window_uncached got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b1, 32'h00001234, 1'b1, 6'h00});
        end
        idle(4);
    endtask

    task automatic test_priority_miss();
        write_win(2'd0, 8'hCC);  // vseg 4 -> pseg 1
        write_win(2'd1, 8'hD4);  // vseg 4 -> pseg 2
        tlb_req = 1'b1; tlb_vaddr = 32'h80000010;
        step();
        tlb_vaddr = 32'h60000000;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b1, 32'h20000010, 1'b0, 6'h00}) begin
            n_bad++; $display("FAIL priority got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b1, 32'h20000010, 1'b0, 6'h00});
        end
        step();
        tlb_req = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b0, 32'h60000000, 1'b0, 6'h3F}) begin
            n_bad++; $display("FAIL miss got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b0, 32'h60000000, 1'b0, 6'h3F});
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic exp_b, exp_f;
        for (int k = 0; k < 7; k++) begin
            tlb_req = (k < 4);
            if (k < 4) begin
                tlb_vaddr  = $urandom();
                da_mode    = 1'($urandom_range(0, 1));
                da_uncache = 1'($urandom_range(0, 1));
            end
            step();
            exp_b = (k + 1 <= 6);
            exp_f = (k + 1 >= 3) && (k + 1 <= 6);
            n_cmp++;
            if (b3 !== exp_b) begin
                n_bad++; $display("FAIL b2b_busy T+%0d got=%b exp=%b", k + 1, b3, exp_b);
            end
            n_cmp++;
            if (f3 !== exp_f) begin
                n_bad++; $display("FAIL b2b_finish T+%0d got=%b exp=%b", k + 1, f3, exp_f);
            end
        end
        tlb_req = 1'b0; da_mode = 1'b0;
        idle(3);
    endtask

    task automatic test_cancel();
        for (int j = 1; j <= 5; j++) begin
            tlb_req    = (j <= 3);
            tlb_cancel = (j == 3);
            tlb_vaddr  = 32'h80000100 + 32'(j);
            step();
            if (j >= 3) begin
                n_cmp++;
                if (f3 !== 1'b0) begin
                    n_bad++; $display("FAIL cancel_finish T+%0d got=%b exp=0", j, f3);
                end
            end
            if (j == 3) begin
                n_cmp++;
                if (b3 !== 1'b0) begin
                    n_bad++; $display("FAIL cancel_busy T+3 got=%b exp=0", b3);
                end
            end
        end
        tlb_req = 1'b0; tlb_cancel = 1'b0;
        idle(3);
    endtask

    task automatic test_same_cycle_cfg();
        write_win(2'd0, 8'h00);
        write_win(2'd1, 8'h00);
        cfg_wen = 1'b1; cfg_idx = 2'd0; cfg_wdata = 8'hDF;  // vseg 7 -> pseg 3
        tlb_req = 1'b1; tlb_vaddr = 32'hE0000000;
        step();
        cfg_wen = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b0, 32'hE0000000, 1'b0, 6'h3F}) begin
            n_bad++; $display("FAIL cfg_old got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b0, 32'hE0000000, 1'b0, 6'h3F});
        end
        step();
        tlb_req = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b1, 32'h60000000, 1'b0, 6'h00}) begin
            n_bad++; $display("FAIL cfg_new got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b1, 32'h60000000, 1'b0, 6'h00});
        end
        write_win(2'd2, 8'hF9);  // index beyond NUM_WIN, must be ignored
        tlb_req = 1'b1; tlb_vaddr = 32'h20000000;
        step();
        tlb_req = 1'b0;
        n_cmp++;
        if ({f1, h1, p1, u1, e1} !== {1'b1, 1'b0, 32'h20000000, 1'b0, 6'h3F}) begin
            n_bad++; $display("FAIL cfg_bad_idx got=%h exp=%h", {f1, h1, p1, u1, e1}, {1'b1, 1'b0, 32'h20000000, 1'b0, 6'h3F});
        end
        idle(4);
    endtask

    task automatic test_reset_midflight();
        tlb_req = 1'b1; tlb_vaddr = 32'hE0000040;
        step();
        tlb_vaddr = 32'hE0000080;
        step();
        tlb_req = 1'b0;
        resetn = 1'b0;
        clear_model();
        step();
        resetn = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            n_cmp++;
            if ({f3, b3, h3, p3, u3, e3} !== '0) begin
                n_bad++; $display("FAIL midreset_L3 step=%0d got=%h exp=0", j, {f3, b3, h3, p3, u3, e3});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tlb_req    = ($urandom_range(0, 3) != 0);
            tlb_vaddr  = $urandom();
            da_mode    = ($urandom_range(0, 3) == 0);
            da_uncache = 1'($urandom_range(0, 1));
            tlb_cancel = ($urandom_range(0, 15) == 0);
            cfg_wen    = ($urandom_range(0, 7) == 0);
            cfg_idx    = 2'($urandom_range(0, 3));
            cfg_wdata  = 8'($urandom_range(0, 255));
            step();
        end
        da_mode = 1'b0;
        idle(5);
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        test_reset();
        test_da();
        test_window();
        test_priority_miss();
        test_back_to_back();
        test_cancel();
        test_same_cycle_cfg();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
